// File: rtl/clock_core.sv
// clock_core: timekeeping and mode-control stage for the seven-segment display
// controller. Divides mclk down to a one-second tick, keeps the time of day,
// holds an alarm time, and runs the button-driven mode state machine.
//
// Ports:
//   mclk, rst        system clock; asynchronous active-high reset
//   btn_mode         pulse: advance to the next mode (ignored in ALARM)
//   btn_up           pulse: increment the field selected by the mode
//   btn_ack          pulse: acknowledge an active alarm
//   alarm_en         level: enable alarm matching
//   nowH, nowM       current time of day (0..23, 0..59)
//   timerH, timerM   alarm time (0..23, 0..59)
//   master_status    mode code (RUN=0, SET_NOW_H=1, SET_NOW_M=2,
//                    SET_TIM_H=3, SET_TIM_M=4, ALARM=8)
//   sec_p            one-cycle pulse once per second
//   alarm            high while in ALARM
module clock_core #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned ALARM_SEC = 60
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_ack,
  input  logic       alarm_en,
  output logic [4:0] nowH,
  output logic [5:0] nowM,
  output logic [4:0] timerH,
  output logic [5:0] timerM,
  output logic [3:0] master_status,
  output logic       sec_p,
  output logic       alarm
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ACNT_MAX  = AW'(ALARM_SEC);

  localparam logic [3:0] ST_RUN       = 4'd0;
  localparam logic [3:0] ST_SET_NOW_H = 4'd1;
  localparam logic [3:0] ST_SET_NOW_M = 4'd2;
  localparam logic [3:0] ST_SET_TIM_H = 4'd3;
  localparam logic [3:0] ST_SET_TIM_M = 4'd4;
  localparam logic [3:0] ST_ALARM     = 4'd8;

  logic [PW-1:0] presc_q, presc_d;
  logic          sec_p_q, sec_p_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [4:0]    tim_h_q, tim_h_d;
  logic [5:0]    tim_m_q, tim_m_d;
  logic [3:0]    state_q, state_d;
  logic [AW-1:0] acnt_q, acnt_d;

  logic          tick;
  logic          advance;
  logic          match;
  logic [5:0]    adv_sec;
  logic [5:0]    adv_min;
  logic [4:0]    adv_hour;
  logic [AW-1:0] acnt_inc;

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    sec_p_d  = tick;

    // Carry chain for one second of advance; only applied when time runs.
    adv_sec  = sec_q + 6'd1;
    adv_min  = min_q;
    adv_hour = hour_q;
    if (sec_q == 6'd59) begin
      adv_sec = '0;
      if (min_q == 6'd59) begin
        adv_min  = '0;
        adv_hour = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
      end else begin
        adv_min = min_q + 6'd1;
      end
    end

    advance = tick && (state_q != ST_SET_NOW_H) && (state_q != ST_SET_NOW_M);
    // Match is judged on the post-increment time, so sec==0 limits it to
    // one edge per minute and an acknowledged alarm cannot re-fire.
    match   = advance && alarm_en && (state_q == ST_RUN) && (adv_sec == 6'd0) &&
              (adv_min == tim_m_q) && (adv_hour == tim_h_q);

    sec_d    = advance ? adv_sec  : sec_q;
    min_d    = advance ? adv_min  : min_q;
    hour_d   = advance ? adv_hour : hour_q;
    tim_h_d  = tim_h_q;
    tim_m_d  = tim_m_q;
    state_d  = state_q;
    acnt_d   = acnt_q;
    acnt_inc = acnt_q + 1'b1;

    case (state_q)
      ST_RUN: begin
        if (btn_mode)   state_d = ST_SET_NOW_H;
        else if (match) state_d = ST_ALARM;
      end
      ST_SET_NOW_H: begin
        if (btn_mode)    state_d = ST_SET_NOW_M;
        else if (btn_up) hour_d  = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
      end
      ST_SET_NOW_M: begin
        if (btn_mode) begin
          state_d = ST_SET_TIM_H;
          sec_d   = '0;
        end else if (btn_up) begin
          min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        end
      end
      ST_SET_TIM_H: begin
        if (btn_mode)    state_d = ST_SET_TIM_M;
        else if (btn_up) tim_h_d = (tim_h_q == 5'd23) ? '0 : tim_h_q + 5'd1;
      end
      ST_SET_TIM_M: begin
        if (btn_mode)    state_d = ST_RUN;
        else if (btn_up) tim_m_d = (tim_m_q == 6'd59) ? '0 : tim_m_q + 6'd1;
      end
      ST_ALARM: begin
        if (tick) acnt_d = acnt_inc;
        // Ack and timeout on the same edge collapse into one exit.
        if (btn_ack || (tick && (acnt_inc == ACNT_MAX))) begin
          state_d = ST_RUN;
          acnt_d  = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      sec_p_q <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      tim_h_q <= '0;
      tim_m_q <= '0;
      state_q <= ST_RUN;
      acnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sec_p_q <= sec_p_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tim_h_q <= tim_h_d;
      tim_m_q <= tim_m_d;
      state_q <= state_d;
      acnt_q  <= acnt_d;
    end
  end

  assign nowH          = hour_q;
  assign nowM          = min_q;
  assign timerH        = tim_h_q;
  assign timerM        = tim_m_q;
  assign master_status = state_q;
  assign sec_p         = sec_p_q;
  assign alarm         = (state_q == ST_ALARM);

endmodule

// File: tb/tb_clock_core.sv
// Testbench for clock_core (CLK_HZ=4, ALARM_SEC=3). Stimulus updates a
// seconds-of-day reference model and queues the expected outputs for each
// edge; a separate monitor pops and compares on the falling edge.
module tb_clock_core;

  localparam int CLK_HZ    = 4;
  localparam int ALARM_SEC = 3;

  logic       mclk = 1'b0;
  logic       rst  = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_ack  = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] nowH;
  logic [5:0] nowM;
  logic [4:0] timerH;
  logic [5:0] timerM;
  logic [3:0] master_status;
  logic       sec_p;
  logic       alarm;

  clock_core #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .mclk(mclk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_ack(btn_ack), .alarm_en(alarm_en), .nowH(nowH), .nowM(nowM),
    .timerH(timerH), .timerM(timerM), .master_status(master_status),
    .sec_p(sec_p), .alarm(alarm)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int h; int m; int th; int tm; int st; int sp; int al;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: time as seconds of day, mode as its status code.
  int pc, t, th, tm, mode, acnt, secp;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_mode(input int md);
    case (md)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    pc = 0; t = 0; th = 0; tm = 0; mode = 0; acnt = 0; secp = 0;
  endtask

  task automatic model_step(input bit m, input bit u, input bit a);
    bit tick, adv;
    tick = (pc == CLK_HZ - 1);
    pc   = (pc + 1) % CLK_HZ;
    secp = tick;
    adv  = tick && mode != 1 && mode != 2;
    if (adv) t = (t + 1) % 86400;
    if (mode == 8) begin
      if (tick) acnt++;
      if (a || acnt >= ALARM_SEC) begin
        mode = 0;
        acnt = 0;
      end
    end else if (m) begin
      if (mode == 2) t = t - t % 60;
      mode = next_mode(mode);
    end else if (mode == 0) begin
      if (adv && alarm_en && t % 60 == 0 && t / 3600 == th && (t / 60) % 60 == tm) begin
        mode = 8;
        acnt = 0;
      end
    end else if (u) begin
      case (mode)
        1: t = ((t / 3600 + 1) % 24) * 3600 + t % 3600;
        2: t = (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60 + t % 60;
        3: th = (th + 1) % 24;
        4: tm = (tm + 1) % 60;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit m, input bit u, input bit a);
    exp_t e;
    btn_mode = m; btn_up = u; btn_ack = a;
    @(posedge mclk);
    model_step(m, u, a);
    e.h = t / 3600; e.m = (t / 60) % 60; e.th = th; e.tm = tm;
    e.st = mode; e.sp = secp; e.al = (mode == 8) ? 1 : 0;
    sb.push_back(e);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic press(input bit m, input bit u, input bit a);
    step(m, u, a);
    step(0, 0, 0);
  endtask

  task automatic press_up(input int n);
    repeat (n) press(0, 1, 0);
  endtask

  // From RUN: walk all four set modes, landing on the requested values.
  task automatic set_all(input int h, input int mn, input int th_t, input int tm_t);
    press(1, 0, 0);
    press_up((h - t / 3600 + 24) % 24);
    press(1, 0, 0);
    press_up((mn - (t / 60) % 60 + 60) % 60);
    press(1, 0, 0);
    press_up((th_t - th + 24) % 24);
    press(1, 0, 0);
    press_up((tm_t - tm + 60) % 60);
    press(1, 0, 0);
  endtask

  task automatic wait_alarm(input string name);
    int n;
    n = 0;
    while (mode != 8 && n < 2000) begin
      step(0, 0, 0);
      n++;
    end
    chk(name, mode, 8);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nowH"}, int'(nowH), 0);
    chk({tag, "_nowM"}, int'(nowM), 0);
    chk({tag, "_timerH"}, int'(timerH), 0);
    chk({tag, "_timerM"}, int'(timerM), 0);
    chk({tag, "_status"}, int'(master_status), 0);
    chk({tag, "_sec_p"}, int'(sec_p), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
  endtask

  // Monitor: one expected entry per rising edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("nowH", int'(nowH), e.h);
        chk("nowM", int'(nowM), e.m);
        chk("timerH", int'(timerH), e.th);
        chk("timerM", int'(timerM), e.tm);
        chk("master_status", int'(master_status), e.st);
        chk("sec_p", int'(sec_p), e.sp);
        chk("alarm", int'(alarm), e.al);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk_all_zero("reset");
    @(posedge mclk);
    #1 rst = 1'b0;

    // Ticks every 4th edge, minute rollover after 60 pulses.
    idle(60 * CLK_HZ + 3);

    // Day rollover with the alarm disabled.
    set_all(23, 59, th, tm);
    idle(62 * CLK_HZ);

    // Field wraps: 24 hour ups, then 61 timer-minute ups.
    press(1, 0, 0);
    press_up(24);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press_up(61);
    press(1, 0, 0);
    idle(5);

    // Alarm ended by acknowledge; mode/up/alarm_en changes are ignored in ALARM.
    set_all(0, 0, 0, 2);
    alarm_en = 1'b1;
    wait_alarm("alarm_ack_entry");
    alarm_en = 1'b0;
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    alarm_en = 1'b1;
    idle(8);

    // Alarm auto-clear after ALARM_SEC ticks.
    set_all(0, 0, 0, 2);
    wait_alarm("alarm_auto_entry");
    idle(5 * CLK_HZ);

    // Random button traffic in RUN and set modes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end
    while (mode != 0) press(1, 0, 0);
    idle(4);

    // Mode has priority over up.
    press(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press_up((30 - tm + 60) % 60);
    idle(2);

    // Asynchronous reset between edges in SET_TIM_M.
    @(negedge mclk);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(posedge mclk);
    @(posedge mclk);
    #1 rst = 1'b0;
    idle(3 * CLK_HZ + 2);

    @(negedge mclk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
